// File: rtl/window_mac_engine.sv
// Sequential 3x3 window dot-product engine: sweeps the window/kernel register read ports,
// multiply-accumulates through a one-stage product register, and hands the sum downstream on valid/ready.
module window_mac_engine #(
    parameter int WINDOW_ELEMNT_SIZE = 8,
    parameter int WINDOW_REG_SIZE    = 9,
    parameter int ADDR_SIZE          = 4,
    parameter int ACC_WIDTH          = 20
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_start,
    output logic                          o_busy,
    output logic [ADDR_SIZE-1:0]          o_win_rd_addr,
    input  logic [WINDOW_ELEMNT_SIZE-1:0] i_win_rd_data,
    output logic [ADDR_SIZE-1:0]          o_ker_rd_addr,
    input  logic [WINDOW_ELEMNT_SIZE-1:0] i_ker_rd_data,
    output logic [ACC_WIDTH-1:0]          o_result,
    output logic                          o_valid,
    input  logic                          i_ready
);

    localparam int PROD_WIDTH = 2 * WINDOW_ELEMNT_SIZE;
    localparam logic [ADDR_SIZE-1:0] LAST_IDX = ADDR_SIZE'(WINDOW_REG_SIZE - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_SIZE-1:0]   cnt_q, cnt_d;
    logic [PROD_WIDTH-1:0]  prod_q, prod_d;
    logic                   prod_vld_q, prod_vld_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [ACC_WIDTH-1:0]   result_q, result_d;
    logic [ADDR_SIZE-1:0]   rd_addr;
    logic [ACC_WIDTH-1:0]   prod_ext;

    assign prod_ext = ACC_WIDTH'(prod_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        prod_d     = prod_q;
        prod_vld_d = 1'b0;
        acc_d      = acc_q;
        result_d   = result_q;
        rd_addr    = '0;

        // The accumulator trails the product register by one cycle, so it keeps
        // adding through the DRAIN cycle while the FSM has already left RUN.
        if (prod_vld_q) begin
            acc_d = acc_q + prod_ext;
        end

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    acc_d   = '0;
                end
            end
            ST_RUN: begin
                rd_addr    = cnt_q;
                prod_d     = PROD_WIDTH'(i_win_rd_data) * PROD_WIDTH'(i_ker_rd_data);
                prod_vld_d = 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                result_d = acc_q + prod_ext;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                // Start is only honoured together with the handshake; otherwise the result is held.
                if (i_ready) begin
                    if (i_start) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                        acc_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
            acc_q      <= '0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            prod_q     <= prod_d;
            prod_vld_q <= prod_vld_d;
            acc_q      <= acc_d;
            result_q   <= result_d;
        end
    end

    assign o_busy        = (state_q != ST_IDLE);
    assign o_valid       = (state_q == ST_DONE);
    assign o_win_rd_addr = rd_addr;
    assign o_ker_rd_addr = rd_addr;
    assign o_result      = result_q;

endmodule

// File: tb/tb_window_mac_engine.sv
// Bench for window_mac_engine: transaction-timeline reference model checked every cycle,
// directed scenarios with literal expectations, then randomized start/ready/window traffic.
module tb_window_mac_engine;

    localparam int W   = 8;
    localparam int N   = 9;
    localparam int A   = 4;
    localparam int ACC = 20;
    localparam int LAT = N + 1;   // edges from start acceptance to the edge that raises o_valid

    logic           i_clk   = 1'b0;
    logic           i_rst_n = 1'b1;
    logic           i_start = 1'b0;
    logic           i_ready = 1'b0;
    logic           o_busy;
    logic [A-1:0]   o_win_rd_addr;
    logic [A-1:0]   o_ker_rd_addr;
    logic [W-1:0]   i_win_rd_data;
    logic [W-1:0]   i_ker_rd_data;
    logic [ACC-1:0] o_result;
    logic           o_valid;

    logic [W-1:0] win_arr [16];
    logic [W-1:0] ker_arr [16];

    int vectors     = 0;
    int miscompares = 0;

    // Model: m_age = -1 when idle, else edges since start acceptance (held at LAT while waiting for ready).
    int             m_age     = -1;
    int             m_pending = 0;
    logic [ACC-1:0] m_result  = '0;

    always #5 i_clk = ~i_clk;

    assign i_win_rd_data = win_arr[o_win_rd_addr];
    assign i_ker_rd_data = ker_arr[o_ker_rd_addr];

    window_mac_engine #(
        .WINDOW_ELEMNT_SIZE(W),
        .WINDOW_REG_SIZE   (N),
        .ADDR_SIZE         (A),
        .ACC_WIDTH         (ACC)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_start      (i_start),
        .o_busy       (o_busy),
        .o_win_rd_addr(o_win_rd_addr),
        .i_win_rd_data(i_win_rd_data),
        .o_ker_rd_addr(o_ker_rd_addr),
        .i_ker_rd_data(i_ker_rd_data),
        .o_result     (o_result),
        .o_valid      (o_valid),
        .i_ready      (i_ready)
    );

    function automatic int dot();
        int s = 0;
        for (int k = 0; k < N; k++) s += int'(win_arr[k]) * int'(ker_arr[k]);
        return s;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model advance and per-cycle compare.
    always begin
        @(posedge i_clk);
        if (i_rst_n) begin
            if (m_age == -1) begin
                if (i_start) begin
                    m_age     = 0;
                    m_pending = dot();
                end
            end else if (m_age < LAT) begin
                m_age++;
                if (m_age == LAT) m_result = ACC'(m_pending);
            end else if (i_ready) begin
                if (i_start) begin
                    m_age     = 0;
                    m_pending = dot();
                end else begin
                    m_age = -1;
                end
            end
        end
        @(negedge i_clk);
        if (!i_rst_n) begin
            m_age    = -1;
            m_result = '0;
        end
        chk("busy",     longint'(o_busy),  longint'(m_age >= 0));
        chk("valid",    longint'(o_valid), longint'(m_age == LAT));
        chk("result",   longint'(o_result), longint'(m_result));
        chk("win_addr", longint'(o_win_rd_addr), (m_age >= 0 && m_age < N) ? longint'(m_age) : 0);
        chk("ker_addr", longint'(o_ker_rd_addr), (m_age >= 0 && m_age < N) ? longint'(m_age) : 0);
    end

    task automatic step();
        @(negedge i_clk);
        #1;
    endtask

    task automatic pulse_start();
        step();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
    endtask

    // Counts negedges from the one where start was raised until o_valid is seen.
    task automatic wait_valid(output int n);
        n = 1;
        while (!o_valid && n < 40) begin
            @(negedge i_clk);
            n++;
        end
        #1;
        if (!o_valid) chk("valid_timeout", 0, 1);
    endtask

    task automatic load(input int wsel, input int ksel);
        logic [W-1:0] pat [N];
        pat = '{8'd3, 8'd1, 8'd5, 8'd2, 8'd4, 8'd2, 8'd5, 8'd1, 8'd3};
        for (int k = 0; k < 16; k++) begin
            win_arr[k] = '0;
            ker_arr[k] = '0;
        end
        for (int k = 0; k < N; k++) begin
            case (wsel)
                0: win_arr[k] = pat[k];
                1: win_arr[k] = 8'd255;
                default: win_arr[k] = 8'd2;
            endcase
            case (ksel)
                0: ker_arr[k] = 8'd1;
                1: ker_arr[k] = (k == 4) ? 8'd1 : 8'd0;
                2: ker_arr[k] = 8'd255;
                default: ker_arr[k] = 8'd3;
            endcase
        end
    endtask

    initial begin
        int n;
        logic [ACC-1:0] held;
        load(0, 0);
        #1 i_rst_n = 1'b0;
        repeat (3) step();
        chk("rst_result", longint'(o_result), 0);
        i_rst_n = 1'b1;
        step();

        // 1: all-ones kernel
        chk("model_dot_ones", dot(), 26);
        i_ready = 1'b1;
        pulse_start();
        wait_valid(n);
        chk("t1_latency", n, 11);
        chk("t1_result", longint'(o_result), 26);
        repeat (2) step();

        // 2: centre-only kernel
        load(0, 1);
        chk("model_dot_center", dot(), 4);
        pulse_start();
        wait_valid(n);
        chk("t2_result", longint'(o_result), 4);
        repeat (2) step();

        // 3: full-scale operands
        load(1, 2);
        pulse_start();
        wait_valid(n);
        chk("t3_result", longint'(o_result), 585225);
        repeat (2) step();

        // 4: back-pressure in DONE, start ignored
        load(0, 0);
        i_ready = 1'b0;
        pulse_start();
        wait_valid(n);
        held = o_result;
        chk("t4_result", longint'(held), 26);
        repeat (5) begin
            step();
            i_start = ~i_start;
            chk("t4_valid_held", longint'(o_valid), 1);
            chk("t4_result_held", longint'(o_result), longint'(held));
        end
        i_start = 1'b0;
        i_ready = 1'b1;
        step();
        chk("t4_idle_valid", longint'(o_valid), 0);
        chk("t4_idle_busy", longint'(o_busy), 0);

        // 5: back-to-back restart from DONE
        i_ready = 1'b0;
        pulse_start();
        wait_valid(n);
        load(2, 3);
        i_ready = 1'b1;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        chk("t5_valid_drop", longint'(o_valid), 0);
        chk("t5_busy", longint'(o_busy), 1);
        wait_valid(n);
        chk("t5_latency", n, 11);
        chk("t5_result", longint'(o_result), 54);
        repeat (2) step();

        // 6: reset mid-RUN, then a clean full run
        load(0, 0);
        pulse_start();
        n = 0;
        while (o_win_rd_addr != 4'd4 && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        chk("t6_reached_addr4", longint'(o_win_rd_addr), 4);
        #1 i_rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", longint'(o_busy), 0);
        chk("t6_rst_valid", longint'(o_valid), 0);
        chk("t6_rst_addr", longint'(o_win_rd_addr), 0);
        chk("t6_rst_result", longint'(o_result), 0);
        step();
        i_rst_n = 1'b1;
        load(1, 2);
        pulse_start();
        wait_valid(n);
        chk("t6_latency", n, 11);
        chk("t6_result", longint'(o_result), 585225);
        repeat (2) step();

        // Randomized traffic; operands only change while no computation is in flight.
        for (int c = 0; c < 1500; c++) begin
            step();
            if ((m_age == -1 || m_age == LAT) && ($urandom % 3 == 0)) begin
                for (int k = 0; k < N; k++) begin
                    win_arr[k] = ($urandom % 8 == 0) ? 8'd255 : W'($urandom);
                    ker_arr[k] = ($urandom % 8 == 0) ? 8'd255 : W'($urandom);
                end
            end
            i_start = ($urandom % 3 == 0);
            i_ready = ($urandom % 3 != 0);
        end
        i_start = 1'b0;
        i_ready = 1'b1;
        repeat (15) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
